// File: rtl/resp_signature_checker.sv
// resp_signature_checker: folds each accepted response vector into a MISR
// signature and, after NUM_VECTORS vectors, compares it with exp_sig.
// Optional feature macro: RESP_TRACE_FIFO_EN adds a 4-entry FWFT trace FIFO
// of fold words with a sticky overflow flag.
module resp_signature_checker #(
  parameter int unsigned          Y_WIDTH     = 242,
  parameter int unsigned          SIG_WIDTH   = 32,
  parameter logic [SIG_WIDTH-1:0] POLY        = 32'h04C11DB7,
  parameter logic [SIG_WIDTH-1:0] SEED        = 32'hFFFFFFFF,
  parameter int unsigned          NUM_VECTORS = 21
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 y_valid,
  input  logic [Y_WIDTH-1:0]   y,
  input  logic [SIG_WIDTH-1:0] exp_sig,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [SIG_WIDTH-1:0] signature,
  output logic [7:0]           vec_count
`ifdef RESP_TRACE_FIFO_EN
  ,
  input  logic                 rd_en,
  output logic [SIG_WIDTH-1:0] rd_data,
  output logic                 rd_empty,
  output logic                 ovf
`endif
);

  localparam int unsigned NSLICE = (Y_WIDTH + SIG_WIDTH - 1) / SIG_WIDTH;
  localparam int unsigned EXT_W  = NSLICE * SIG_WIDTH;
  localparam logic [7:0]  NV     = 8'(NUM_VECTORS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_DONE} state_t;

  state_t               state_q;
  logic [SIG_WIDTH-1:0] sig_q, sig_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 pass_q, busy_q, done_q;
  logic [EXT_W-1:0]     y_ext;
  logic [SIG_WIDTH-1:0] fold;
  logic                 accept;

  // A vector arriving with start is discarded; start wins.
  assign accept = (state_q == S_RUN) && y_valid && !start;

  // Zero-extend y to whole slices and XOR all slices together.
  always_comb begin
    y_ext = '0;
    y_ext[Y_WIDTH-1:0] = y;
    fold = '0;
    for (int unsigned i = 0; i < NSLICE; i++) begin
      fold = fold ^ y_ext[i*SIG_WIDTH +: SIG_WIDTH];
    end
  end

  // Next signature and vector count for one accepted vector.
  always_comb begin
    sig_d = {sig_q[SIG_WIDTH-2:0], 1'b0} ^ (sig_q[SIG_WIDTH-1] ? POLY : '0) ^ fold;
    cnt_d = cnt_q + 8'd1;
  end

  // Control FSM with registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (start) begin
      state_q <= S_RUN;
      sig_q   <= SEED;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (y_valid) begin
            sig_q <= sig_d;
            cnt_q <= cnt_d;
            if (cnt_d == NV) state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          pass_q  <= (sig_q == exp_sig);
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        default: ;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = sig_q;
  assign vec_count = cnt_q;

`ifdef RESP_TRACE_FIFO_EN
  logic [SIG_WIDTH-1:0] fifo_mem [4];
  logic [1:0]           wr_ptr_q, rd_ptr_q;
  logic [2:0]           fcnt_q;
  logic                 ovf_q;
  logic                 fifo_full, fifo_wr, fifo_rd;

  assign fifo_full = (fcnt_q == 3'd4);
  assign rd_empty  = (fcnt_q == 3'd0);
  assign fifo_rd   = rd_en && !rd_empty;
  // A read in the same cycle frees the slot, so a write when full still lands.
  assign fifo_wr   = accept && (!fifo_full || fifo_rd);
  assign rd_data   = fifo_mem[rd_ptr_q];
  assign ovf       = ovf_q;

  // Trace storage; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (fifo_wr) fifo_mem[wr_ptr_q] <= fold;
  end

  // Pointers, occupancy and sticky overflow; start flushes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
      ovf_q    <= 1'b0;
    end else if (start) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (fifo_wr) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (fifo_rd) rd_ptr_q <= rd_ptr_q + 2'd1;
      case ({fifo_wr, fifo_rd})
        2'b10:   fcnt_q <= fcnt_q + 3'd1;
        2'b01:   fcnt_q <= fcnt_q - 3'd1;
        default: ;
      endcase
      if (accept && !fifo_wr) ovf_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_resp_signature_checker.sv
module tb_resp_signature_checker;

  localparam logic [31:0] POLY   = 32'h04C11DB7;
  localparam logic [31:0] SEED_A = 32'hFFFFFFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic         a_start = 0, a_yv = 0;
  logic [241:0] a_y = '0;
  logic [31:0]  a_exp = '0;
  logic         a_busy, a_done, a_pass;
  logic [31:0]  a_sig;
  logic [7:0]   a_cnt;

  logic         b_start = 0, b_yv = 0;
  logic [241:0] b_y = '0;
  logic [31:0]  b_exp = '0;
  logic         b_busy, b_done, b_pass;
  logic [31:0]  b_sig;
  logic [7:0]   b_cnt;

`ifdef RESP_TRACE_FIFO_EN
  logic        a_rd = 0, b_rd = 0;
  logic [31:0] a_rdata, b_rdata;
  logic        a_empty, b_empty, a_ovf, b_ovf;
`endif

  int n_err = 0;
  int n_checks = 0;

  logic [31:0]  m_sig;
  int           m_cnt;
  logic [241:0] v;
  logic [31:0]  exp_folds[$];

  always #5 clk = ~clk;

  resp_signature_checker dut_a (
    .clk(clk), .rst(rst), .start(a_start), .y_valid(a_yv), .y(a_y), .exp_sig(a_exp),
    .busy(a_busy), .done(a_done), .pass(a_pass), .signature(a_sig), .vec_count(a_cnt)
`ifdef RESP_TRACE_FIFO_EN
    , .rd_en(a_rd), .rd_data(a_rdata), .rd_empty(a_empty), .ovf(a_ovf)
`endif
  );

  resp_signature_checker #(.SEED(32'h0), .NUM_VECTORS(2)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .y_valid(b_yv), .y(b_y), .exp_sig(b_exp),
    .busy(b_busy), .done(b_done), .pass(b_pass), .signature(b_sig), .vec_count(b_cnt)
`ifdef RESP_TRACE_FIFO_EN
    , .rd_en(b_rd), .rd_data(b_rdata), .rd_empty(b_empty), .ovf(b_ovf)
`endif
  );

  // Fold as arithmetic: XOR of successive 32-bit chunks of y taken by shifting.
  function automatic logic [31:0] fold_m(input logic [241:0] val);
    logic [255:0] e;
    logic [31:0]  r;
    e = 256'(val);
    r = 0;
    for (int i = 0; i < 8; i++) r = r ^ 32'(e >> (32 * i));
    return r;
  endfunction

  // Multiply by x modulo the polynomial, then add the fold.
  function automatic logic [31:0] misr_m(input logic [31:0] s, input logic [31:0] f);
    longint unsigned t;
    t = longint'(s) * 2;
    if (t >= 64'h1_0000_0000) t = (t - 64'h1_0000_0000) ^ longint'(POLY);
    return 32'(t) ^ f;
  endfunction

  function automatic logic [241:0] rand_y();
    logic [241:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = (r << 32) | 242'($urandom);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic a_go();
    a_start = 1;
    cyc();
    a_start = 0;
    m_sig = SEED_A;
    m_cnt = 0;
  endtask

  task automatic a_vec(input logic [241:0] val);
    a_yv = 1;
    a_y = val;
    cyc();
    a_yv = 0;
    m_sig = misr_m(m_sig, fold_m(val));
    m_cnt++;
  endtask

  task automatic b_vec(input logic [241:0] val);
    b_yv = 1;
    b_y = val;
    cyc();
    b_yv = 0;
  endtask

  initial begin
    // Reset values
    repeat (2) cyc();
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_done", 32'(a_done), 0);
    chk("rst_pass", 32'(a_pass), 0);
    chk("rst_sig", a_sig, SEED_A);
    chk("rst_cnt", 32'(a_cnt), 0);
    rst = 0;
    cyc();

    // y_valid in IDLE is ignored
    a_yv = 1; a_y = rand_y();
    cyc();
    a_yv = 0;
    chk("idle_sig", a_sig, SEED_A);
    chk("idle_cnt", 32'(a_cnt), 0);
    chk("idle_busy", 32'(a_busy), 0);

    // Reset mid-run takes effect without a clock edge
    a_go();
    chk("start_busy", 32'(a_busy), 1);
    for (int i = 0; i < 3; i++) a_vec(rand_y());
    chk("pre_rst_cnt", 32'(a_cnt), 3);
    chk("pre_rst_sig", a_sig, m_sig);
    #2 rst = 1;
    #1;
    chk("async_rst_busy", 32'(a_busy), 0);
    chk("async_rst_cnt", 32'(a_cnt), 0);
    chk("async_rst_sig", a_sig, SEED_A);
    cyc();
    rst = 0;
    cyc();

    // Full 21-vector run with 2-cycle gaps
    a_go();
    for (int i = 0; i < 21; i++) begin
      a_vec(rand_y());
      if (i < 20) begin
        cyc();
        cyc();
      end
    end
    chk("run_sig", a_sig, m_sig);
    chk("run_cnt", 32'(a_cnt), 21);
    chk("check_busy", 32'(a_busy), 1);
    chk("check_done", 32'(a_done), 0);
    a_exp = m_sig;
    cyc();
    chk("done_done", 32'(a_done), 1);
    chk("done_pass", 32'(a_pass), 1);
    chk("done_busy", 32'(a_busy), 0);
    // y_valid pulses in DONE are ignored
    for (int i = 0; i < 3; i++) begin
      a_yv = 1; a_y = rand_y();
      cyc();
      a_yv = 0;
    end
    chk("done_hold_sig", a_sig, m_sig);
    chk("done_hold_cnt", 32'(a_cnt), 21);
    chk("done_hold_pass", 32'(a_pass), 1);
    chk("done_hold_done", 32'(a_done), 1);

    // start together with y_valid mid-run discards the vector
    a_go();
    chk("restart_pass_clr", 32'(a_pass), 0);
    chk("restart_done_clr", 32'(a_done), 0);
    for (int i = 0; i < 5; i++) a_vec(rand_y());
    chk("mid_cnt", 32'(a_cnt), 5);
    a_start = 1; a_yv = 1; a_y = rand_y();
    cyc();
    a_start = 0; a_yv = 0;
    m_sig = SEED_A;
    m_cnt = 0;
    chk("collide_sig", a_sig, SEED_A);
    chk("collide_cnt", 32'(a_cnt), 0);
    chk("collide_busy", 32'(a_busy), 1);
    v = rand_y();
    a_vec(v);
    chk("after_collide_sig", a_sig, m_sig);
    chk("after_collide_cnt", 32'(a_cnt), 1);

    // SEED=0, two vectors, matching golden value
    b_exp = 32'h2;
    b_start = 1;
    cyc();
    b_start = 0;
    b_vec(242'd1);
    chk("b_sig1", b_sig, 32'h1);
    b_vec(242'd0);
    chk("b_sig2", b_sig, 32'h2);
    chk("b_check_done", 32'(b_done), 0);
    cyc();
    chk("b_done", 32'(b_done), 1);
    chk("b_pass", 32'(b_pass), 1);

    // Same run, wrong golden value
    b_exp = 32'h3;
    b_start = 1;
    cyc();
    b_start = 0;
    chk("b2_pass_clr", 32'(b_pass), 0);
    b_vec(242'd1);
    b_vec(242'd0);
    cyc();
    chk("b2_done", 32'(b_done), 1);
    chk("b2_pass", 32'(b_pass), 0);
    chk("b2_sig", b_sig, 32'h2);

`ifdef RESP_TRACE_FIFO_EN
    // Trace FIFO: overflow and first-word-fall-through readout
    a_go();
    chk("fifo_ovf_clr", 32'(a_ovf), 0);
    chk("fifo_empty0", 32'(a_empty), 1);
    exp_folds.delete();
    for (int i = 0; i < 6; i++) begin
      v = rand_y();
      exp_folds.push_back(fold_m(v));
      a_vec(v);
    end
    chk("fifo_ovf", 32'(a_ovf), 1);
    chk("fifo_not_empty", 32'(a_empty), 0);
    for (int i = 0; i < 4; i++) begin
      chk("fifo_rd_data", a_rdata, exp_folds[i]);
      a_rd = 1;
      cyc();
      a_rd = 0;
    end
    chk("fifo_empty_end", 32'(a_empty), 1);
    a_go();
    chk("fifo_ovf_flush", 32'(a_ovf), 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
